// File: rtl/scan_decoder_pkg.sv
// Shared state encodings and mode constants for the scan_decoder block.
// Optional wrap counter is enabled by defining SCAN_DECODER_WRAP_CNT_EN.
package scan_decoder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DIRECT = 2'd1,
    ST_SCAN   = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

endpackage

// File: rtl/scan_decoder_if.sv
// Control/status bundle for scan_decoder; wrap_cnt exists only when
// SCAN_DECODER_WRAP_CNT_EN is defined.
interface scan_decoder_if #(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
`ifdef SCAN_DECODER_WRAP_CNT_EN
    ,
    parameter int WRAP_CNT_W = 8
`endif
);
    localparam int OUT_W = 1 << SEL_W;

    logic               enable;
    logic               mode;
    logic [SEL_W-1:0]   in;
    logic               load;
    logic [DWELL_W-1:0] dwell;
    logic [OUT_W-1:0]   out;
    logic [SEL_W-1:0]   idx;
    logic               valid;
    logic               wrap;
`ifdef SCAN_DECODER_WRAP_CNT_EN
    logic [WRAP_CNT_W-1:0] wrap_cnt;
`endif

    modport master (
        output enable, mode, in, load, dwell,
`ifdef SCAN_DECODER_WRAP_CNT_EN
        input  wrap_cnt,
`endif
        input  out, idx, valid, wrap
    );

    modport slave (
        input  enable, mode, in, load, dwell,
`ifdef SCAN_DECODER_WRAP_CNT_EN
        output wrap_cnt,
`endif
        output out, idx, valid, wrap
    );

endinterface

// File: rtl/scan_decoder_onehot_dec.sv
// Combinational binary-to-one-hot decoder with no enable.
module onehot_dec #(
    parameter int SEL_W = 3
) (
    input  logic [SEL_W-1:0]        i_sel,
    output logic [(1<<SEL_W)-1:0]   o_onehot
);
    localparam int OUT_W = 1 << SEL_W;

    assign o_onehot = {{(OUT_W-1){1'b0}}, 1'b1} << i_sel;

endmodule

// File: rtl/scan_decoder.sv
// Registered N-to-2^N one-hot decoder with DIRECT and SCAN modes.
// Define SCAN_DECODER_WRAP_CNT_EN to add the wrap_cnt output and counter.
module scan_decoder
    import scan_decoder_pkg::*;
#(
    parameter int SEL_W   = 3,
    parameter int DWELL_W = 4
`ifdef SCAN_DECODER_WRAP_CNT_EN
    ,
    parameter int WRAP_CNT_W = 8
`endif
) (
    input  logic         clk,
    input  logic         rst,
    scan_decoder_if.slave bus
);
    localparam int OUT_W = 1 << SEL_W;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [SEL_W-1:0]   r_idx;
    logic [SEL_W-1:0]   w_idx_nxt;
    logic [DWELL_W-1:0] r_cnt;
    logic [DWELL_W-1:0] w_cnt_nxt;
    logic [OUT_W-1:0]   r_out;
    logic [OUT_W-1:0]   w_onehot;
    logic               r_valid;
    logic               w_valid_nxt;
    logic               r_wrap;
    logic               w_wrap_nxt;

    // Decoding the next index lets out register in step with idx.
    onehot_dec #(.SEL_W(SEL_W)) u_dec (
        .i_sel    (w_idx_nxt),
        .o_onehot (w_onehot)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
            r_cnt   <= '0;
            r_out   <= '0;
            r_valid <= 1'b0;
            r_wrap  <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_idx   <= w_idx_nxt;
            r_cnt   <= w_cnt_nxt;
            r_out   <= w_valid_nxt ? w_onehot : '0;
            r_valid <= w_valid_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end

    always_comb begin
        w_state_nxt = ST_IDLE;
        w_idx_nxt   = '0;
        w_cnt_nxt   = '0;
        w_valid_nxt = 1'b0;
        w_wrap_nxt  = 1'b0;

        if (bus.enable) begin
            w_state_nxt = (bus.mode == MODE_DIRECT) ? ST_DIRECT : ST_SCAN;
        end

        case (w_state_nxt)
            ST_DIRECT: begin
                w_idx_nxt   = bus.in;
                w_valid_nxt = 1'b1;
            end
            ST_SCAN: begin
                w_valid_nxt = 1'b1;
                // Entry and load both restart at in; load never pulses wrap.
                if (r_state != ST_SCAN || bus.load) begin
                    w_idx_nxt = bus.in;
                end else if (r_cnt >= bus.dwell) begin
                    w_idx_nxt  = r_idx + 1'b1;
                    w_wrap_nxt = &r_idx;
                end else begin
                    w_idx_nxt = r_idx;
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            default: ;
        endcase
    end

    assign bus.out   = r_out;
    assign bus.idx   = r_idx;
    assign bus.valid = r_valid;
    assign bus.wrap  = r_wrap;

`ifdef SCAN_DECODER_WRAP_CNT_EN
    logic [WRAP_CNT_W-1:0] r_wrap_cnt;

    // Cleared only by rst, so the count survives IDLE.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wrap_cnt <= '0;
        end else if (w_wrap_nxt) begin
            r_wrap_cnt <= r_wrap_cnt + 1'b1;
        end
    end

    assign bus.wrap_cnt = r_wrap_cnt;
`endif

endmodule

// File: tb/tb_scan_decoder.sv
// Randomised and directed self-checking bench for scan_decoder against a
// cycle-level behavioural model.
module tb_scan_decoder;
    import scan_decoder_pkg::*;

    localparam int SEL_W      = 3;
    localparam int DWELL_W    = 4;
    localparam int OUT_W      = 1 << SEL_W;
    localparam int WRAP_CNT_W = 8;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int n_checks = 0;
    int n_errors = 0;

`ifdef SCAN_DECODER_WRAP_CNT_EN
    scan_decoder_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .WRAP_CNT_W(WRAP_CNT_W)) bus ();
    scan_decoder #(.SEL_W(SEL_W), .DWELL_W(DWELL_W), .WRAP_CNT_W(WRAP_CNT_W)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
`else
    scan_decoder_if #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) bus ();
    scan_decoder #(.SEL_W(SEL_W), .DWELL_W(DWELL_W)) dut (
        .clk (clk), .rst (rst), .bus (bus)
    );
`endif

    always #5 clk = ~clk;

    // Behavioural model: position, how many cycles it has been shown, and
    // whether the previous cycle was already scanning.
    int m_idx = 0;
    int m_age = 0;
    bit m_scanning = 0;
    bit m_valid = 0;
    bit m_wrap = 0;
    int m_wrap_cnt = 0;
    logic [OUT_W-1:0] exp_out;

    function automatic void model_reset();
        m_idx = 0; m_age = 0; m_scanning = 0; m_valid = 0; m_wrap = 0;
        m_wrap_cnt = 0;
    endfunction

    function automatic void model_edge();
        m_wrap = 0;
        if (rst) begin
            model_reset();
        end else if (!bus.enable) begin
            m_idx = 0; m_age = 0; m_scanning = 0; m_valid = 0;
        end else if (bus.mode == MODE_DIRECT) begin
            m_idx = int'(bus.in); m_age = 0; m_scanning = 0; m_valid = 1;
        end else if (!m_scanning || bus.load) begin
            m_idx = int'(bus.in); m_age = 1; m_scanning = 1; m_valid = 1;
        end else if (m_age > int'(bus.dwell)) begin
            m_wrap = (m_idx == OUT_W - 1);
            m_idx  = (m_idx + 1) % OUT_W;
            m_age  = 1;
        end else begin
            m_age++;
        end
        if (m_wrap) m_wrap_cnt = (m_wrap_cnt + 1) % (1 << WRAP_CNT_W);
        exp_out = m_valid ? (OUT_W'(1) << m_idx) : '0;
    endfunction

    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic set_in(input bit en, input bit md, input int sel, input bit ld, input int dw);
        bus.enable = en;
        bus.mode   = md;
        bus.in     = SEL_W'(sel);
        bus.load   = ld;
        bus.dwell  = DWELL_W'(dw);
    endtask

    task automatic test_reset();
        set_in(0, 0, 0, 0, 0);
        #2;
        n_checks++;
        if ({bus.out, bus.idx, bus.valid, bus.wrap} !== '0) begin
            n_errors++;
            $display("FAIL reset_async got out=%h idx=%0d valid=%b wrap=%b want all 0",
                     bus.out, bus.idx, bus.valid, bus.wrap);
        end
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        tick();
        n_checks++;
        if ({bus.out, bus.idx, bus.valid, bus.wrap} !== '0) begin
            n_errors++;
            $display("FAIL reset_idle got out=%h idx=%0d valid=%b wrap=%b want all 0",
                     bus.out, bus.idx, bus.valid, bus.wrap);
        end
    endtask

    task automatic test_direct();
        for (int i = 0; i < OUT_W; i++) begin
            set_in(1, MODE_DIRECT, i, (i % 2), $urandom_range(0, 15));
            tick();
            n_checks++;
            if (bus.out !== (OUT_W'(1) << i) || bus.idx !== SEL_W'(i) || bus.valid !== 1'b1
                || bus.wrap !== 1'b0) begin
                n_errors++;
                $display("FAIL direct_sweep in=%0d got out=%h idx=%0d valid=%b want out=%h",
                         i, bus.out, bus.idx, bus.valid, OUT_W'(1) << i);
            end
        end
        set_in(1, MODE_DIRECT, 5, 0, 0);
        tick();
        n_checks++;
        if (bus.out !== 8'b0010_0000 || bus.idx !== 3'd5 || bus.valid !== 1'b1) begin
            n_errors++;
            $display("FAIL direct_in5 got out=%b idx=%0d valid=%b want 00100000 5 1",
                     bus.out, bus.idx, bus.valid);
        end
    endtask

    task automatic test_disable();
        set_in(1, MODE_DIRECT, 4, 0, 0);
        tick();
        set_in(0, MODE_DIRECT, 4, 0, 0);
        tick();
        n_checks++;
        if ($isunknown({bus.out, bus.idx, bus.valid, bus.wrap})
            || bus.out !== 8'h00 || bus.idx !== 3'd0 || bus.valid !== 1'b0) begin
            n_errors++;
            $display("FAIL disable got out=%h idx=%h valid=%b want 00 0 0",
                     bus.out, bus.idx, bus.valid);
        end
    endtask

    task automatic test_scan_dwell2();
        logic [7:0] want_out [8] = '{8'h40, 8'h40, 8'h40, 8'h80, 8'h80, 8'h80, 8'h01, 8'h01};
        bit         want_wrp [8] = '{0, 0, 0, 0, 0, 0, 1, 0};
        set_in(0, MODE_SCAN, 0, 0, 2);
        tick();
        set_in(1, MODE_SCAN, 6, 0, 2);
        for (int c = 0; c < 8; c++) begin
            tick();
            n_checks++;
            if (bus.out !== want_out[c] || bus.wrap !== want_wrp[c] || bus.valid !== 1'b1) begin
                n_errors++;
                $display("FAIL scan_dwell2 cyc=%0d got out=%h wrap=%b want out=%h wrap=%b",
                         c, bus.out, bus.wrap, want_out[c], want_wrp[c]);
            end
        end
    endtask

    task automatic test_load_priority();
        set_in(1, MODE_SCAN, 7, 1, 0);
        tick();
        set_in(1, MODE_SCAN, 3, 1, 0);
        tick();
        n_checks++;
        if (bus.idx !== 3'd3 || bus.wrap !== 1'b0 || bus.out !== 8'h08) begin
            n_errors++;
            $display("FAIL load_priority got idx=%0d wrap=%b out=%h want 3 0 08",
                     bus.idx, bus.wrap, bus.out);
        end
        set_in(1, MODE_SCAN, 0, 0, 0);
        tick();
        n_checks++;
        if (bus.idx !== 3'd4 || bus.out !== 8'h10) begin
            n_errors++;
            $display("FAIL load_then_step got idx=%0d out=%h want 4 10", bus.idx, bus.out);
        end
    endtask

    task automatic test_dwell_lowered();
        set_in(1, MODE_DIRECT, 0, 0, 5);
        tick();
        set_in(1, MODE_SCAN, 1, 0, 5);
        for (int c = 0; c < 4; c++) tick();
        set_in(1, MODE_SCAN, 1, 0, 1);
        tick();
        n_checks++;
        if (bus.idx !== 3'd2 || bus.idx !== SEL_W'(m_idx)) begin
            n_errors++;
            $display("FAIL dwell_lowered got idx=%0d want 2", bus.idx);
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            set_in(($urandom_range(0, 15) != 0), ($urandom_range(0, 3) != 0),
                   $urandom_range(0, OUT_W - 1), ($urandom_range(0, 9) == 0),
                   $urandom_range(0, 3));
            tick();
            n_checks++;
            if ({bus.out, bus.idx, bus.valid, bus.wrap} !==
                {exp_out, SEL_W'(m_idx), m_valid, m_wrap}) begin
                n_errors++;
                $display("FAIL random cyc=%0d got out=%h idx=%0d valid=%b wrap=%b want out=%h idx=%0d valid=%b wrap=%b",
                         c, bus.out, bus.idx, bus.valid, bus.wrap, exp_out, m_idx, m_valid, m_wrap);
            end
        end
    endtask

    task automatic test_async_reset();
        set_in(1, MODE_SCAN, 5, 1, 0);
        tick();
        set_in(1, MODE_SCAN, 0, 0, 0);
        tick();
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        n_checks++;
        if ({bus.out, bus.idx, bus.valid, bus.wrap} !== '0) begin
            n_errors++;
            $display("FAIL reset_midscan got out=%h idx=%0d valid=%b wrap=%b want all 0",
                     bus.out, bus.idx, bus.valid, bus.wrap);
        end
        set_in(1, MODE_SCAN, 2, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.out, bus.valid} !== '0) begin
            n_errors++;
            $display("FAIL reset_release got out=%h valid=%b want 0 0", bus.out, bus.valid);
        end
        tick();
        n_checks++;
        if (bus.idx !== 3'd2 || bus.out !== 8'h04 || bus.valid !== 1'b1 || bus.idx !== SEL_W'(m_idx)) begin
            n_errors++;
            $display("FAIL reset_reentry got idx=%0d out=%h valid=%b want 2 04 1",
                     bus.idx, bus.out, bus.valid);
        end
    endtask

    task automatic test_wrap_period();
        int last = -1;
        int wraps = 0;
        set_in(0, MODE_SCAN, 0, 0, 0);
        tick();
        set_in(1, MODE_SCAN, OUT_W - 1, 0, 0);
        for (int c = 0; c < 3 * OUT_W; c++) begin
            tick();
            if (bus.wrap === 1'b1) begin
                if (last >= 0) begin
                    n_checks++;
                    if (c - last != OUT_W) begin
                        n_errors++;
                        $display("FAIL wrap_period got %0d want %0d", c - last, OUT_W);
                    end
                end
                last = c;
                wraps++;
            end
        end
        n_checks++;
        if (wraps != 3) begin
            n_errors++;
            $display("FAIL wrap_count got %0d want 3", wraps);
        end
`ifdef SCAN_DECODER_WRAP_CNT_EN
        n_checks++;
        if (bus.wrap_cnt !== WRAP_CNT_W'(m_wrap_cnt)) begin
            n_errors++;
            $display("FAIL wrap_cnt got %0d want %0d", bus.wrap_cnt, m_wrap_cnt);
        end
        set_in(0, MODE_SCAN, 0, 0, 0);
        tick();
        tick();
        n_checks++;
        if (bus.wrap_cnt !== WRAP_CNT_W'(m_wrap_cnt) || bus.wrap !== 1'b0) begin
            n_errors++;
            $display("FAIL wrap_cnt_hold got %0d want %0d", bus.wrap_cnt, m_wrap_cnt);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_direct();
        test_disable();
        test_scan_dwell2();
        test_load_priority();
        test_dwell_lowered();
        test_random();
        test_async_reset();
        test_wrap_period();
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
